// File: rtl/game_pkg.sv
// Shared types and sizing for the dinosaur-game controller and its score counter.
package game_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_HIT,
        ST_OVER
    } game_state_t;

    localparam int SPEED_W      = 4;
    localparam int SCORE_DIGITS = 4;
    localparam int SCORE_W      = 4 * SCORE_DIGITS;

endpackage

// File: rtl/game_if.sv
// Frame-level signals exchanged between the game controller and the VGA/sprite side.
interface game_if;
    import game_pkg::*;

    logic               vs;
    logic               START;
    logic               px_dinosaur;
    logic               px_obstacle;
    logic               game_status;
    logic               game_over;
    logic               freeze;
    logic               frame_tick;
    logic [SPEED_W-1:0] speed;
    logic [SCORE_W-1:0] score;

    modport master (
        output vs, START, px_dinosaur, px_obstacle,
        input  game_status, game_over, freeze, frame_tick, speed, score
    );

    modport slave (
        input  vs, START, px_dinosaur, px_obstacle,
        output game_status, game_over, freeze, frame_tick, speed, score
    );

endinterface

// File: rtl/bcd_counter4.sv
// Four-digit BCD score counter: ripple increment, synchronous clear, holds at 9999.
module bcd_counter4
    import game_pkg::*;
(
    input  logic               CLK,
    input  logic               RESET,
    input  logic               inc,
    input  logic               clear,
    output logic [SCORE_W-1:0] value,
    output logic               low_roll
);

    logic [SCORE_W-1:0]      value_reg, value_next;
    logic [SCORE_DIGITS-1:0] carry;
    logic                    saturated;

    assign saturated = (value_reg == {SCORE_DIGITS{4'h9}});
    assign carry[0]  = inc & ~saturated;

    // Flags that an increment taken now rolls digits 1..0 from 99 to 00; independent of inc
    assign low_roll  = (value_reg[7:0] == 8'h99) & ~saturated;

    genvar gi;
    generate
        for (gi = 0; gi < SCORE_DIGITS; gi++) begin : g_digit
            logic [3:0] digit;
            assign digit = value_reg[gi*4 +: 4];
            assign value_next[gi*4 +: 4] = carry[gi] ? ((digit == 4'd9) ? 4'd0 : digit + 4'd1) : digit;
            if (gi < SCORE_DIGITS - 1) begin : g_carry
                assign carry[gi+1] = carry[gi] & (digit == 4'd9);
            end
        end
    endgenerate

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            value_reg <= '0;
        end else if (clear) begin
            value_reg <= '0;
        end else begin
            value_reg <= value_next;
        end
    end

    assign value = value_reg;

endmodule

// File: rtl/game_controller.sv
// Frame-synchronous game sequencer: state, scroll speed and BCD score, all updated at vs fall.
module game_controller
    import game_pkg::*;
#(
    parameter int SCORE_FRAMES = 6,
    parameter int SPEED_INIT   = 2,
    parameter int SPEED_MAX    = 10,
    parameter int HIT_FRAMES   = 30
) (
    input logic   CLK,
    input logic   RESET,
    game_if.slave bus
);

    localparam int CNT_MAX = (HIT_FRAMES > SCORE_FRAMES) ? HIT_FRAMES : SCORE_FRAMES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    game_state_t        state_reg, state_next;
    logic [CNT_W-1:0]   frame_cnt_reg, frame_cnt_next;
    logic [SPEED_W-1:0] speed_reg, speed_next;
    logic               vs_d_reg, start_d_reg, start_req_reg, hit_latch_reg;
    logic               frame_tick, start_rise, overlap, entering_run;
    logic               score_inc, score_clr, score_low_roll;
    logic [SCORE_W-1:0] score_val;

    assign frame_tick   = vs_d_reg & ~bus.vs;
    assign start_rise   = bus.START & ~start_d_reg;
    assign overlap      = (state_reg == ST_RUN) & bus.vs & bus.px_dinosaur & bus.px_obstacle;
    assign entering_run = (state_next == ST_RUN) & (state_reg != ST_RUN);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            vs_d_reg      <= 1'b0;
            start_d_reg   <= 1'b0;
            start_req_reg <= 1'b0;
            hit_latch_reg <= 1'b0;
        end else begin
            vs_d_reg    <= bus.vs;
            start_d_reg <= bus.START;
            if (entering_run) begin
                start_req_reg <= 1'b0;
            end else if (start_rise && (state_reg == ST_IDLE || state_reg == ST_OVER)) begin
                start_req_reg <= 1'b1;
            end
            // Collision is only meaningful on visible pixels; the tick itself falls in blanking
            if (frame_tick) begin
                hit_latch_reg <= 1'b0;
            end else if (overlap) begin
                hit_latch_reg <= 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_reg     <= ST_IDLE;
            frame_cnt_reg <= '0;
            speed_reg     <= SPEED_W'(SPEED_INIT);
        end else begin
            state_reg     <= state_next;
            frame_cnt_reg <= frame_cnt_next;
            speed_reg     <= speed_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        frame_cnt_next = frame_cnt_reg;
        speed_next     = speed_reg;
        score_inc      = 1'b0;
        score_clr      = 1'b0;
        if (frame_tick) begin
            case (state_reg)
                ST_IDLE, ST_OVER: begin
                    if (start_req_reg) begin
                        state_next     = ST_RUN;
                        frame_cnt_next = '0;
                        speed_next     = SPEED_W'(SPEED_INIT);
                        score_clr      = 1'b1;
                    end
                end
                ST_RUN: begin
                    // A collision in this frame pre-empts the score increment
                    if (hit_latch_reg) begin
                        state_next     = ST_HIT;
                        frame_cnt_next = '0;
                    end else if (frame_cnt_reg == CNT_W'(SCORE_FRAMES - 1)) begin
                        frame_cnt_next = '0;
                        score_inc      = 1'b1;
                        if (score_low_roll && speed_reg < SPEED_W'(SPEED_MAX)) begin
                            speed_next = speed_reg + SPEED_W'(1);
                        end
                    end else begin
                        frame_cnt_next = frame_cnt_reg + CNT_W'(1);
                    end
                end
                ST_HIT: begin
                    if (frame_cnt_reg == CNT_W'(HIT_FRAMES - 1)) begin
                        state_next     = ST_OVER;
                        frame_cnt_next = '0;
                    end else begin
                        frame_cnt_next = frame_cnt_reg + CNT_W'(1);
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    bcd_counter4 u_score (
        .CLK      (CLK),
        .RESET    (RESET),
        .inc      (score_inc),
        .clear    (score_clr),
        .value    (score_val),
        .low_roll (score_low_roll)
    );

    assign bus.game_status = (state_reg == ST_RUN);
    assign bus.freeze      = (state_reg == ST_HIT);
    assign bus.game_over   = (state_reg == ST_OVER);
    assign bus.frame_tick  = frame_tick;
    assign bus.speed       = speed_reg;
    assign bus.score       = score_val;

endmodule

// File: tb/tb_game_controller.sv
// Directed bench for game_controller: a behavioural model feeds a scoreboard checked around frame ticks.
module tb_game_controller;
    import game_pkg::*;

    localparam int SF_A   = 6;
    localparam int SF_B   = 1;
    localparam int HF     = 30;
    localparam int SP_INI = 2;
    localparam int SP_MAX = 10;

    typedef struct packed {
        game_state_t st;
        int          cnt;
        int          score;
        int          speed;
        logic        req;
        logic        hit;
    } model_t;

    typedef struct packed {
        logic        b;
        logic        gs;
        logic        go;
        logic        fr;
        logic        ft;
        logic [3:0]  speed;
        logic [15:0] score;
    } exp_t;

    logic CLK = 1'b0;
    logic rst_a, rst_b, vs, start_a, start_b, px_d, px_o;

    game_if bus_a ();
    game_if bus_b ();

    assign bus_a.vs = vs;           assign bus_b.vs = vs;
    assign bus_a.px_dinosaur = px_d; assign bus_b.px_dinosaur = px_d;
    assign bus_a.px_obstacle = px_o; assign bus_b.px_obstacle = px_o;
    assign bus_a.START = start_a;   assign bus_b.START = start_b;

    game_controller #(.SCORE_FRAMES(SF_A), .SPEED_INIT(SP_INI), .SPEED_MAX(SP_MAX), .HIT_FRAMES(HF))
        dut_a (.CLK(CLK), .RESET(rst_a), .bus(bus_a));

    // Second instance scores every frame so the 9999 ceiling is reachable in a short run
    game_controller #(.SCORE_FRAMES(SF_B), .SPEED_INIT(SP_INI), .SPEED_MAX(SP_MAX), .HIT_FRAMES(HF))
        dut_b (.CLK(CLK), .RESET(rst_b), .bus(bus_b));

    always #5 CLK = ~CLK;

    exp_t   sb[$];
    model_t ma, mb;
    int     checks = 0;
    int     passed = 0;

    function automatic model_t model_reset();
        model_t m;
        m.st = ST_IDLE; m.cnt = 0; m.score = 0; m.speed = SP_INI; m.req = 1'b0; m.hit = 1'b0;
        return m;
    endfunction

    function automatic model_t model_tick(input model_t m, input int sf);
        model_t n = m;
        case (m.st)
            ST_IDLE, ST_OVER: if (m.req) begin
                n.st = ST_RUN; n.cnt = 0; n.score = 0; n.speed = SP_INI; n.req = 1'b0;
            end
            ST_RUN: if (m.hit) begin
                n.st = ST_HIT; n.cnt = 0;
            end else begin
                n.cnt = m.cnt + 1;
                if (n.cnt == sf) begin
                    n.cnt = 0;
                    if (m.score < 9999) n.score = m.score + 1;
                    n.speed = SP_INI + n.score / 100;
                    if (n.speed > SP_MAX) n.speed = SP_MAX;
                end
            end
            ST_HIT: begin
                n.cnt = m.cnt + 1;
                if (n.cnt == HF) begin n.st = ST_OVER; n.cnt = 0; end
            end
            default: ;
        endcase
        n.hit = 1'b0;
        return n;
    endfunction

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic exp_t expect_of(input model_t m, input logic b, input logic ft);
        exp_t e;
        e.b = b; e.gs = (m.st == ST_RUN); e.go = (m.st == ST_OVER); e.fr = (m.st == ST_HIT);
        e.ft = ft; e.speed = 4'(m.speed); e.score = to_bcd(m.score);
        return e;
    endfunction

    task automatic chk(input string tag, input string field, input logic [15:0] obs, input logic [15:0] expv);
        checks++;
        assert (obs === expv) begin
            passed++;
        end else begin
            $error("FAIL %s.%s observed=%0h expected=%0h", tag, field, obs, expv);
        end
    endtask

    task automatic compare_pop(input string tag);
        exp_t e;
        logic gs, go, fr, ft;
        logic [3:0] sp;
        logic [15:0] sc;
        e = sb.pop_front();
        if (e.b) begin
            gs = bus_b.game_status; go = bus_b.game_over; fr = bus_b.freeze;
            ft = bus_b.frame_tick; sp = bus_b.speed; sc = bus_b.score;
        end else begin
            gs = bus_a.game_status; go = bus_a.game_over; fr = bus_a.freeze;
            ft = bus_a.frame_tick; sp = bus_a.speed; sc = bus_a.score;
        end
        $display("[%0t] %s dut=%s status=%0b over=%0b freeze=%0b tick=%0b speed=%0d score=%04h",
                 $time, tag, e.b ? "B" : "A", gs, go, fr, ft, sp, sc);
        chk(tag, "game_status", {15'd0, gs}, {15'd0, e.gs});
        chk(tag, "game_over",   {15'd0, go}, {15'd0, e.go});
        chk(tag, "freeze",      {15'd0, fr}, {15'd0, e.fr});
        chk(tag, "frame_tick",  {15'd0, ft}, {15'd0, e.ft});
        chk(tag, "speed",       {12'd0, sp}, {12'd0, e.speed});
        chk(tag, "score",       sc,          e.score);
    endtask

    task automatic check_now(input logic b, input string tag);
        sb.push_back(expect_of(b ? mb : ma, b, 1'b0));
        compare_pop(tag);
    endtask

    // One frame: hi visible cycles, then blanking; the tick edge is the first edge with vs low
    task automatic frame(input logic b, input int hi, input int lo, input logic hit_vis,
                         input logic hit_blank, input logic do_check, input string tag);
        vs = 1'b1;
        if (hit_vis) begin
            px_d = 1'b1; px_o = 1'b1;
            if (ma.st == ST_RUN) ma.hit = 1'b1;
            if (mb.st == ST_RUN) mb.hit = 1'b1;
        end
        for (int i = 0; i < hi; i++) begin
            @(posedge CLK); #1;
            px_d = 1'b0; px_o = 1'b0;
        end
        vs = 1'b0;
        #1;
        if (do_check) begin
            sb.push_back(expect_of(b ? mb : ma, b, 1'b1));
            compare_pop({tag, "/pre"});
        end
        ma = model_tick(ma, SF_A);
        mb = model_tick(mb, SF_B);
        if (do_check) sb.push_back(expect_of(b ? mb : ma, b, 1'b0));
        @(posedge CLK); #1;
        if (do_check) compare_pop({tag, "/post"});
        for (int i = 1; i < lo; i++) begin
            if (i == 1 && hit_blank) begin px_d = 1'b1; px_o = 1'b1; end
            @(posedge CLK); #1;
            px_d = 1'b0; px_o = 1'b0;
        end
    endtask

    task automatic pulse_start(input logic b);
        vs = 1'b1;
        if (b) begin
            start_b = 1'b1;
            if (mb.st == ST_IDLE || mb.st == ST_OVER) mb.req = 1'b1;
        end else begin
            start_a = 1'b1;
            if (ma.st == ST_IDLE || ma.st == ST_OVER) ma.req = 1'b1;
        end
        repeat (5) begin @(posedge CLK); #1; end
        start_a = 1'b0; start_b = 1'b0;
        @(posedge CLK); #1;
    endtask

    // Free-run short frames until the next tick would produce score 'target', then check that tick
    task automatic run_until(input logic b, input int target, input string tag);
        int guard = 0;
        while (guard < 70000 &&
               !(b ? (mb.score == target - 1 && mb.cnt == SF_B - 1)
                   : (ma.score == target - 1 && ma.cnt == SF_A - 1))) begin
            frame(b, 1, 1, 1'b0, 1'b0, 1'b0, "");
            guard++;
        end
        frame(b, 1, 1, 1'b0, 1'b0, 1'b1, tag);
    endtask

    initial begin
        rst_a = 1'b1; rst_b = 1'b1; vs = 1'b1; start_a = 1'b1; start_b = 1'b0;
        px_d = 1'b0; px_o = 1'b0;
        ma = model_reset(); mb = model_reset();

        // Reset held mid-frame with START high, then idle frames
        repeat (3) begin @(posedge CLK); #1; end
        check_now(1'b0, "reset_held");
        start_a = 1'b0;
        @(posedge CLK); #1;
        rst_a = 1'b0; rst_b = 1'b0;
        @(posedge CLK); #1;
        check_now(1'b0, "reset_release");
        for (int i = 0; i < 3; i++) frame(1'b0, 4, 4, 1'b0, 1'b0, 1'b1, $sformatf("idle%0d", i));

        // Start synchronised to the next tick; START during RUN is ignored
        pulse_start(1'b0);
        frame(1'b0, 4, 4, 1'b0, 1'b0, 1'b1, "start");
        pulse_start(1'b0);
        frame(1'b0, 4, 4, 1'b0, 1'b0, 1'b1, "start_in_run");

        // Scoring and speed steps
        run_until(1'b0, 100, "score0100");
        run_until(1'b0, 800, "score0800");
        run_until(1'b0, 900, "score0900");

        // Blanking overlap ignored, visible overlap beats the score tick
        frame(1'b0, 2, 3, 1'b0, 1'b1, 1'b1, "blank_overlap");
        repeat (4) frame(1'b0, 1, 1, 1'b0, 1'b0, 1'b0, "");
        frame(1'b0, 3, 2, 1'b1, 1'b0, 1'b1, "hit");
        pulse_start(1'b0);
        repeat (28) frame(1'b0, 1, 1, 1'b0, 1'b0, 1'b0, "");
        frame(1'b0, 1, 1, 1'b0, 1'b0, 1'b1, "hit_tick29");
        frame(1'b0, 1, 1, 1'b0, 1'b0, 1'b1, "hit_tick30");
        frame(1'b0, 2, 2, 1'b0, 1'b0, 1'b1, "over_hold0");
        frame(1'b0, 2, 2, 1'b0, 1'b0, 1'b1, "over_hold1");

        // Restart from OVER
        pulse_start(1'b0);
        frame(1'b0, 3, 3, 1'b0, 1'b0, 1'b1, "restart");

        // Asynchronous reset in the middle of HIT
        repeat (2) frame(1'b0, 1, 1, 1'b0, 1'b0, 1'b0, "");
        frame(1'b0, 2, 2, 1'b1, 1'b0, 1'b1, "hit2");
        vs = 1'b1;
        #2;
        rst_a = 1'b1;
        ma = model_reset();
        #1;
        check_now(1'b0, "async_reset_hit");
        @(posedge CLK); #1;
        rst_a = 1'b0;

        // Score ceiling on the fast-scoring instance
        pulse_start(1'b1);
        frame(1'b1, 1, 1, 1'b0, 1'b0, 1'b1, "b_start");
        run_until(1'b1, 9998, "b_score9998");
        for (int i = 0; i < 12; i++) frame(1'b1, 1, 1, 1'b0, 1'b0, 1'b1, $sformatf("b_sat%0d", i));

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/game_controller.md
Name: game_controller

Overview:
- Frame-synchronous sequencer for the dinosaur game. Owns game state (idle / running / hit / game over), the scroll speed fed to the ground and obstacle blocks, and the BCD score.
- Replaces the ad-hoc start/trigger logic in the top level.
- All state changes occur only at frame boundaries (the vs falling edge, i.e. start of blanking), so the ground, jump and obstacle blocks never see a mid-frame change.

Parameters:
- SCORE_FRAMES, 6: running frames per +1 score.
- SPEED_INIT, 2: speed value at reset and at each new game.
- SPEED_MAX, 10: speed saturation value.
- HIT_FRAMES, 30: frames frozen in HIT before GAME_OVER.

Ports:
- CLK  in  1  system clock; the only clock.
- RESET  in  1  asynchronous, active-high reset.
- vs  in  1  VGA vertical sync (low = blanking); same clock domain.
- START  in  1  debounced start button, active-high level.
- px_dinosaur  in  1  dinosaur pixel active at the current scan position.
- px_obstacle  in  1  obstacle pixel active at the current scan position.
- game_status  out  1  1 while in RUN; gates the jump, ground and obstacle blocks.
- game_over  out  1  1 while in OVER.
- freeze  out  1  1 while in HIT; scrolling halts and the last frame is held.
- speed  out  4  scroll pixels per frame.
- score  out  16  4-digit BCD score, digit 3 most significant.
- frame_tick  out  1  one-cycle pulse per frame boundary.

Behaviour:
- Reset (async, RESET=1):
  - State goes to IDLE.
  - game_status=0, game_over=0, freeze=0, frame_tick=0.
  - speed=SPEED_INIT, score=0.
  - All internal latches and counters are cleared.
  - Reset has the same effect from any state, including mid-HIT.
- Frame tick:
  - vs_d is vs registered.
  - frame_tick = vs_d & ~vs, a single cycle per frame.
  - Every state transition below takes effect on the CLK edge that ends the frame_tick cycle.
- Start request:
  - start_d is START registered.
  - A START rising edge sets start_req, but only in IDLE or OVER; it is ignored in RUN and HIT.
  - start_req is cleared when the state enters RUN.
- Collision:
  - hit_latch is set on any cycle with state==RUN, vs==1, px_dinosaur==1 and px_obstacle==1.
  - hit_latch is cleared on each frame_tick.
  - An overlap during blanking (vs==0) is ignored.
- States (transitions on frame_tick only):
  - IDLE: start_req -> RUN. On this transition score=0, speed=SPEED_INIT, frame counter=0.
  - RUN:
    - hit_latch -> HIT. Score is not incremented on this tick; collision beats the score increment.
    - Otherwise the frame counter increments. When it reaches SCORE_FRAMES-1 it wraps to 0 and score increments by 1 (BCD).
  - HIT: the frame counter counts HIT_FRAMES ticks, then the state goes to OVER.
  - OVER: start_req -> RUN, with the same initialisation as from IDLE.
- Output decode:
  - game_status=(state==RUN).
  - freeze=(state==HIT).
  - game_over=(state==OVER).
  - All three are registered/decoded from the state register; no combinational input paths.
- Score arithmetic:
  - 4-digit BCD ripple; each digit wraps 9 -> 0 with a carry.
  - 9999 saturates (no further increment, no wrap).
  - When digits 1..0 roll from 99 to 00, speed increments on the same tick.
- Speed rules:
  - Speed saturates at SPEED_MAX.
  - Speed only changes on frame_tick, so it is stable across a visible frame.
- Latency:
  - START edge to game_status=1: up to one frame plus one cycle.
  - Collision pixel to freeze=1: at the next frame_tick.

Decomposition:
- Shared package game_pkg:
  - state enum (IDLE, RUN, HIT, OVER);
  - the SPEED width constant (4);
  - the score digit count (4).
- One sub-module, bcd_counter4: 4-digit BCD incrementer with inc/clear inputs, a saturate-at-9999 rule, and a "low two digits rolled to 00" output.
- The FSM, frame tick logic, collision latch and speed logic stay in game_controller.

Test Plan:
1. Reset/idle: assert RESET mid-frame with START held, then release -> outputs game_status=0, game_over=0, freeze=0, speed=2, score=0000; no change across 3 frames without a START edge.
2. Start sync: pulse START for 5 cycles mid-frame -> game_status rises exactly on the next frame_tick edge, not before; a second START pulse during RUN has no effect.
3. Scoring: run 600 frames with no collision -> score=0100 and speed=3 on the 600th tick; continue to score 0800 -> speed=10; beyond that, speed stays at 10.
4. Collision:
   - Overlap px_dinosaur&px_obstacle for 1 cycle with vs=1 on a frame whose tick would increment score -> on that tick freeze=1, game_status=0, score unchanged.
   - 30 ticks later -> game_over=1.
   - Overlap during vs=0 -> ignored.
5. Restart from OVER: START edge -> at the next tick score=0000, speed=2, game_status=1.
6. Saturation and async reset:
   - Preload to score 9998 via a run, then 12 frames -> score holds 9999.
   - Assert RESET mid-HIT -> state IDLE immediately, freeze=0 without waiting for CLK.
